// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 decode/issue stage.
// issue_t is the registered issue-slot payload presented on out_*.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      shamt;
        logic            use_shamt;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } issue_t;

    // Sign-extend a 12-bit I-type immediate to XLEN.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/rv32_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, x0 never busy.
// Reports raw busy state for rs1/rs2/rd lookups and whether a same-cycle
// writeback targets a busy looked-up register (the bypass "hit").
module rv32_scoreboard
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  logic [4:0]  set_idx_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_idx_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        rd_busy_o,
    output logic        rs1_hit_o,
    output logic        rs2_hit_o,
    output logic        rd_hit_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear on writeback first so a same-index set in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register, dropped by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];

    assign rs1_hit_o = busy_q[rs1_i] && clr_i && (clr_idx_i == rs1_i);
    assign rs2_hit_o = busy_q[rs2_i] && clr_i && (clr_idx_i == rs2_i);
    assign rd_hit_o  = busy_q[rd_i]  && clr_i && (clr_idx_i == rd_i);

    assign busy_o = busy_q;

endmodule

// File: rtl/rv32_alu_issue.sv
// RV32 decode/issue stage: decodes OP / OP-IMM into ALU controls, checks the
// busy-bit scoreboard for RAW/WAW hazards and holds the result in a single
// back-pressurable output slot (1-cycle latency, 1 per cycle throughput).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on slot state, scoreboard and in_instr (never on
// in_valid); the output slot holds all out_* stable while out_valid && !out_ready.
//
// Optional feature: define RV32_ISSUE_BYPASS_EN to let a same-cycle writeback
// resolve a hazard and forward wb_data into the matching operand. Without it
// the stage stalls that cycle and issues on the next one from the regfile.
// dbg_busy exposes the scoreboard busy vector for observation.
module rv32_alu_issue
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [4:0]      out_shamt,
    output logic            out_use_shamt,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal,
    output logic [31:0]     dbg_busy
);

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_addr;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode   = in_instr[6:0];
    assign rd_addr  = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign funct7   = in_instr[31:25];

    logic is_op;
    logic is_op_imm;
    logic is_shift_imm;
    logic legal;

    assign is_op        = (opcode == OPC_OP);
    assign is_op_imm    = (opcode == OPC_OP_IMM);
    assign is_shift_imm = is_op_imm && ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Legality: OP alt encoding only for ADD/SUB and SRL/SRA; OP-IMM shifts
    // only allow the alt encoding for SRAI; other OP-IMM ignore instr[31:25].
    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_op_imm) begin
            if (is_shift_imm)
                legal = (funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == 3'b101));
            else
                legal = 1'b1;
        end
    end

    // Scoreboard
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        rs1_hit, rs2_hit, rd_hit;
    logic        sb_set;
    logic        accept;
    issue_t      issue_d;

    assign sb_set = accept && issue_d.rd_we;

    rv32_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (sb_set),
        .set_idx_i  (rd_addr),
        .clr_i      (wb_valid),
        .clr_idx_i  (wb_rd),
        .rs1_i      (rs1_addr),
        .rs2_i      (rs2_addr),
        .rd_i       (rd_addr),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .rs1_hit_o  (rs1_hit),
        .rs2_hit_o  (rs2_hit),
        .rd_hit_o   (rd_hit),
        .busy_o     (dbg_busy)
    );

    // Hazard blocking and operand selection
    logic            rs1_blk, rs2_blk, rd_blk;
    logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef RV32_ISSUE_BYPASS_EN
    assign rs1_blk = rs1_busy && !rs1_hit;
    assign rs2_blk = rs2_busy && !rs2_hit;
    assign rd_blk  = rd_busy  && !rd_hit;
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : (rs1_hit ? wb_data : rs1_data);
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : (rs2_hit ? wb_data : rs2_data);
`else
    logic unused_bypass;
    assign unused_bypass = ^{rs1_hit, rs2_hit, rd_hit, wb_data};
    assign rs1_blk = rs1_busy;
    assign rs2_blk = rs2_busy;
    assign rd_blk  = rd_busy;
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
`endif

    logic hazard;
    logic slot_free;

    // Illegal instructions skip the hazard check; rs2 matters only for OP.
    assign hazard    = legal && (rs1_blk || (is_op && rs2_blk) || rd_blk);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && !hazard;
    assign accept    = in_valid && in_ready;

    // Decode into the next slot payload; illegal words carry only the flag.
    always_comb begin
        issue_d = '0;
        if (!legal) begin
            issue_d.illegal = 1'b1;
        end else begin
            issue_d.in1    = rs1_val;
            issue_d.shamt  = in_instr[24:20];
            issue_d.funct3 = funct3;
            issue_d.rd     = rd_addr;
            issue_d.rd_we  = (rd_addr != 5'd0);
            if (is_op) begin
                issue_d.in2    = rs2_val;
                issue_d.funct7 = funct7;
            end else begin
                issue_d.in2 = sext12(in_instr[31:20]);
                if (is_shift_imm) begin
                    issue_d.use_shamt = 1'b1;
                    issue_d.funct7    = funct7;
                end
            end
        end
    end

    // Output slot
    issue_t slot_q, slot_d;
    logic   valid_q, valid_d;

    // Load on accept, drain on consume, otherwise hold.
    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        if (accept) begin
            slot_d  = issue_d;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register with asynchronous reset to an empty, zeroed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_in1       = slot_q.in1;
    assign out_in2       = slot_q.in2;
    assign out_shamt     = slot_q.shamt;
    assign out_use_shamt = slot_q.use_shamt;
    assign out_funct3    = slot_q.funct3;
    assign out_funct7    = slot_q.funct7;
    assign out_rd        = slot_q.rd;
    assign out_rd_we     = slot_q.rd_we;
    assign out_illegal   = slot_q.illegal;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Testbench for rv32_alu_issue: table of decode vectors plus hand-written
// hazard, back-pressure, illegal-instruction and async-reset sequences.
module tb_rv32_alu_issue;
    import rv32_pkg::*;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_in1, out_in2;
    logic [4:0]  out_shamt;
    logic        out_use_shamt;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] dbg_busy;

    rv32_alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in1(out_in1), .out_in2(out_in2), .out_shamt(out_shamt),
        .out_use_shamt(out_use_shamt), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal), .dbg_busy(dbg_busy)
    );

    issue_t act;
    always_comb begin
        act = '{in1: out_in1, in2: out_in2, shamt: out_shamt,
                use_shamt: out_use_shamt, funct3: out_funct3, funct7: out_funct7,
                rd: out_rd, rd_we: out_rd_we, illegal: out_illegal};
    end

    // Scoreboard
    int     n_checks = 0;
    int     n_fail = 0;
    issue_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic check_out(input string name);
        issue_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got output with no expected entry, expected queued entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, " valid"}, out_valid, 1'b1);
            chk(name, act, e);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = instr;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    function automatic issue_t mk(input logic [31:0] in1, input logic [31:0] in2,
                                  input logic [4:0] sh, input logic us, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] rd,
                                  input logic we, input logic ill);
        issue_t r;
        r = '{in1: in1, in2: in2, shamt: sh, use_shamt: us, funct3: f3,
              funct7: f7, rd: rd, rd_we: we, illegal: ill};
        return r;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        issue_t      exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    issue_t e_ill, e_addi1, e_srai, e_add7, e_add2;

    initial begin
        e_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // ADDI x1,x0,5 (x0 reads zero despite rs1_data)
        vecs[0]  = '{32'h00500093, 32'hDEADBEEF, 32'h0,  mk(0, 5, 5, 0, 0, 7'h00, 1, 1, 0)};
        // SRAI x3,x4,7
        vecs[1]  = '{32'h40725193, 32'h80000000, 32'h0,  mk(32'h80000000, 32'h407, 7, 1, 5, 7'h20, 3, 1, 0)};
        // SUB x5,x6,x7
        vecs[2]  = '{32'h407302B3, 32'h64, 32'h30,       mk(32'h64, 32'h30, 7, 0, 0, 7'h20, 5, 1, 0)};
        // SLLI x8,x9,31
        vecs[3]  = '{32'h01F49413, 32'h1, 32'h0,         mk(32'h1, 32'h1F, 31, 1, 1, 7'h00, 8, 1, 0)};
        // ANDI x10,x11,-1 (funct7 forced to zero)
        vecs[4]  = '{32'hFFF5F513, 32'h12345678, 32'h0,  mk(32'h12345678, 32'hFFFFFFFF, 31, 0, 7, 7'h00, 10, 1, 0)};
        // ADDI x0,x1,1 (rd=0, no write enable)
        vecs[5]  = '{32'h00108013, 32'h10, 32'h0,        mk(32'h10, 32'h1, 1, 0, 0, 7'h00, 0, 0, 0)};
        // SLLI with alt funct7: illegal
        vecs[6]  = '{32'h40109093, 32'h1, 32'h2,         e_ill};
        // OP alt funct7 with funct3=001: illegal
        vecs[7]  = '{32'h40209133, 32'h1, 32'h2,         e_ill};
        // ECALL: illegal opcode
        vecs[8]  = '{32'h00000073, 32'h1, 32'h2,         e_ill};
        // SRA x4,x5,x6
        vecs[9]  = '{32'h4062D233, 32'hF0000000, 32'h3,  mk(32'hF0000000, 32'h3, 6, 0, 5, 7'h20, 4, 1, 0)};
        // ADD x7,x8,x0 (x0 operand reads zero)
        vecs[10] = '{32'h000403B3, 32'h9, 32'hAAAA,      mk(32'h9, 32'h0, 0, 0, 0, 7'h00, 7, 1, 0)};

        e_addi1 = vecs[0].exp;
        e_srai  = vecs[1].exp;
        e_add7  = vecs[10].exp;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset fields", act, '0);
        chk("reset busy", dbg_busy, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", in_ready, 1'b1);
        tick();

        // Table-driven decode vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].instr, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("v%0d ready", i), in_ready, 1'b1);
            chk($sformatf("v%0d rs1_addr", i), rs1_addr, vecs[i].instr[19:15]);
            exp_q.push_back(vecs[i].exp);
            tick();
            in_valid = 1'b0;
            check_out($sformatf("v%0d out", i));
            chk($sformatf("v%0d busy", i), dbg_busy,
                vecs[i].exp.rd_we ? (32'd1 << vecs[i].exp.rd) : 32'd0);
            if (vecs[i].exp.rd_we) writeback(vecs[i].exp.rd, 32'h0);
        end
        tick();
        chk("drained out_valid", out_valid, 1'b0);

        // RAW hazard on x1: ADDI x1,x0,5 then ADD x2,x1,x1
        drive(32'h00500093, 32'h0, 32'h0);
        #1;
        chk("raw addi ready", in_ready, 1'b1);
        exp_q.push_back(e_addi1);
        tick();
        check_out("raw addi out");
        chk("raw busy1", dbg_busy, 32'h2);
        drive(32'h00108133, 32'h0, 32'h0);
        #1;
        chk("raw stall ready", in_ready, 1'b0);
        tick();
        chk("raw stall empty", out_valid, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'd5;
        e_add2   = mk(5, 5, 1, 0, 0, 7'h00, 2, 1, 0);
        #1;
`ifdef RV32_ISSUE_BYPASS_EN
        chk("raw bypass ready", in_ready, 1'b1);
        exp_q.push_back(e_add2);
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
`else
        chk("raw wb-cycle ready", in_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        rs1_data = 32'd5;
        rs2_data = 32'd5;
        #1;
        chk("raw next-cycle ready", in_ready, 1'b1);
        exp_q.push_back(e_add2);
        tick();
        in_valid = 1'b0;
`endif
        check_out("raw add out");
        chk("raw busy2", dbg_busy, 32'h4);
        writeback(5'd2, 32'h0);

        // Back-pressure: SRAI held for 3 cycles, then consume + accept together
        out_ready = 1'b0;
        drive(32'h40725193, 32'h80000000, 32'h0);
        #1;
        chk("bp srai ready", in_ready, 1'b1);
        exp_q.push_back(e_srai);
        tick();
        check_out("bp srai out");
        drive(32'h000403B3, 32'h9, 32'hAAAA);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp stall%0d ready", k), in_ready, 1'b0);
            tick();
            chk($sformatf("bp stall%0d hold", k), act, e_srai);
            chk($sformatf("bp stall%0d valid", k), out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release ready", in_ready, 1'b1);
        exp_q.push_back(e_add7);
        tick();
        in_valid = 1'b0;
        check_out("bp add out");
        chk("bp busy", dbg_busy, 32'h88);
        writeback(5'd3, 32'h0);
        writeback(5'd7, 32'h0);

        // Illegal instructions ignore hazards and leave the scoreboard alone
        drive(32'h00500093, 32'h0, 32'h0);
        #1;
        exp_q.push_back(e_addi1);
        tick();
        check_out("ill addi out");
        drive(32'h40109093, 32'h0, 32'h0);
        #1;
        chk("ill hazard-ignored ready", in_ready, 1'b1);
        exp_q.push_back(e_ill);
        tick();
        check_out("ill slli out");
        chk("ill busy kept", dbg_busy, 32'h2);
        drive(32'h00000073, 32'h0, 32'h0);
        #1;
        exp_q.push_back(e_ill);
        tick();
        check_out("ecall out");
        chk("ecall busy kept", dbg_busy, 32'h2);

        // Asynchronous reset mid-stall with busy[1]=1
        out_ready = 1'b0;
        drive(32'h00108133, 32'h11, 32'h11);
        #1;
        chk("rst stall ready", in_ready, 1'b0);
        tick();
        chk("rst pre valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst async valid", out_valid, 1'b0);
        chk("rst async busy", dbg_busy, 32'h0);
        chk("rst async fields", act, '0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst release ready", in_ready, 1'b1);
        exp_q.push_back(mk(32'h11, 32'h11, 1, 0, 0, 7'h00, 2, 1, 0));
        tick();
        in_valid = 1'b0;
        check_out("rst add out");
        chk("rst add busy", dbg_busy, 32'h4);

        chk("queue drained", exp_q.size(), 0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
